// File: rtl/arb_pkg.sv
// Shared arbiter definitions: requester count, index width and the
// one-hot-to-index encoding used by both the arbiter and its request stage.
package arb_pkg;

   localparam int NREQ = 16;
   localparam int IDW  = 4;

   // OR-encoding: exact for one-hot inputs, cheap for anything else.
   function automatic logic [IDW-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
      logic [IDW-1:0] idx;
      // NOTE: default before the loop so no path leaves idx unassigned (no latch).
      idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (oh[i]) idx = idx | IDW'(i);
      end
      return idx;
   endfunction

   function automatic logic is_onehot(input logic [NREQ-1:0] v);
      return (v != '0) && ((v & (v - NREQ'(1))) == '0);
   endfunction

endpackage

// File: rtl/arb_req_stage_if.sv
// Request-stage bus: per-channel input handshake, arbiter req/gnt pair,
// granted-output handshake and status. master drives, slave is the stage.
interface arb_req_stage_if #(parameter int DW = 8);
   import arb_pkg::*;

   logic [NREQ-1:0]    in_valid;
   logic [NREQ*DW-1:0] in_data;
   logic [NREQ-1:0]    in_ready;
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    gnt;
   logic               out_valid;
   logic [DW-1:0]      out_data;
   logic [IDW-1:0]     out_id;
   logic               out_ready;
   logic               gnt_err;
   logic [7:0]         drop_cnt;

   modport master (
      output in_valid, in_data, gnt, out_ready,
      input  in_ready, req, out_valid, out_data, out_id, gnt_err, drop_cnt
   );

   modport slave (
      input  in_valid, in_data, gnt, out_ready,
      output in_ready, req, out_valid, out_data, out_id, gnt_err, drop_cnt
   );

endinterface

// File: rtl/arb_onehot_enc.sv
// Grant decoder: 16-bit one-hot grant to 4-bit channel index plus validity flag.
module arb_onehot_enc
   import arb_pkg::*;
(
   input  logic [NREQ-1:0] onehot,
   output logic [IDW-1:0]  idx,
   output logic            onehot_ok
);

   assign idx       = onehot_to_idx(onehot);
   assign onehot_ok = is_onehot(onehot);

endmodule

// File: rtl/arb_req_stage.sv
// Per-channel 1-entry holding registers feeding a round-robin arbiter, with a
// registered granted-output stage. ARB_REQ_STAGE_STATS_EN enables drop_cnt.
module arb_req_stage
   import arb_pkg::*;
#(
   parameter int DW = 8
) (
   input logic            clk,
   input logic            rst_n,
   arb_req_stage_if.slave bus
);

   logic [NREQ-1:0] hold_v;
   logic [DW-1:0]   hold_d [NREQ];
   logic [IDW-1:0]  gnt_idx;
   logic            gnt_ok;
   logic            out_v;
   logic [DW-1:0]   out_d;
   logic [IDW-1:0]  out_i;
   logic            err_q;

   logic            can_load;
   logic            take;
   logic [NREQ-1:0] pop;
   logic [NREQ-1:0] load;

   arb_onehot_enc u_enc (
      .onehot    (bus.gnt),
      .idx       (gnt_idx),
      .onehot_ok (gnt_ok)
   );

   assign can_load = ~out_v | bus.out_ready;
   assign take     = gnt_ok & hold_v[gnt_idx] & can_load;
   assign pop      = take ? bus.gnt : '0;
   // Pre-pop state gates capture, so a channel cannot pop and refill together.
   assign load     = bus.in_valid & ~hold_v;

   assign bus.in_ready  = ~hold_v;
   assign bus.req       = hold_v & ~pop;
   assign bus.out_valid = out_v;
   assign bus.out_data  = out_d;
   assign bus.out_id    = out_i;
   assign bus.gnt_err   = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (!rst_n) hold_v <= '0;
      else        hold_v <= (hold_v & ~pop) | load;
   end

   // NOTE: payload storage is not reset; hold_v alone qualifies its contents.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (load[i]) hold_d[i] <= bus.in_data[i*DW +: DW];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_v <= 1'b0;
         out_d <= '0;
         out_i <= '0;
      end else if (take) begin
         out_v <= 1'b1;
         out_d <= hold_d[gnt_idx];
         out_i <= gnt_idx;
      end else if (bus.out_ready) begin
         out_v <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    err_q <= 1'b0;
      else if ((bus.gnt != '0) && !gnt_ok) err_q <= 1'b1;
   end

`ifdef ARB_REQ_STAGE_STATS_EN
   logic       drop;
   logic [7:0] drop_q;

   // Any nonzero grant not consumed: stale, stalled or multi-hot.
   assign drop = (bus.gnt != '0) & ~take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        drop_q <= 8'h00;
      else if (drop && drop_q != 8'hFF)  drop_q <= drop_q + 8'd1;
   end

   assign bus.drop_cnt = drop_q;
`else
   assign bus.drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_arb_req_stage.sv
// Self-checking bench for arb_req_stage: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_arb_req_stage;
   import arb_pkg::*;

   localparam int DW = 8;
`ifdef ARB_REQ_STAGE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_mis = 0;

   always #5 clk = ~clk;

   arb_req_stage_if #(.DW(DW)) bus ();

   arb_req_stage #(.DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Reference model: each channel is a queue of at most one payload.
   logic [DW-1:0] chan_q [NREQ][$];
   bit            m_ov;
   logic [DW-1:0] m_od;
   int            m_oid;
   bit            m_err;
   int            m_drop;

   task automatic model_reset();
      for (int i = 0; i < NREQ; i++) chan_q[i].delete();
      m_ov = 0; m_od = '0; m_oid = 0; m_err = 0; m_drop = 0;
   endtask

   function automatic int gnt_bits();
      int n = 0;
      for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) n++;
      return n;
   endfunction

   function automatic int gnt_chan();
      int k = 0;
      for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) k = i;
      return k;
   endfunction

   function automatic bit model_take();
      return gnt_bits() == 1 && chan_q[gnt_chan()].size() != 0 &&
             (!m_ov || bus.out_ready);
   endfunction

   function automatic logic [NREQ-1:0] exp_req();
      logic [NREQ-1:0] r;
      for (int i = 0; i < NREQ; i++)
         r[i] = chan_q[i].size() != 0 && !(model_take() && bus.gnt[i]);
      return r;
   endfunction

   function automatic logic [NREQ-1:0] exp_ready();
      logic [NREQ-1:0] r;
      for (int i = 0; i < NREQ; i++) r[i] = chan_q[i].size() == 0;
      return r;
   endfunction

   function automatic logic [7:0] exp_drop();
      return STATS ? 8'(m_drop) : 8'h00;
   endfunction

   task automatic model_step();
      bit tk;
      bit pre_full [NREQ];
      int n, k;
      n  = gnt_bits();
      k  = gnt_chan();
      tk = model_take();
      for (int i = 0; i < NREQ; i++) pre_full[i] = chan_q[i].size() != 0;
      if (tk) begin
         m_od  = chan_q[k].pop_front();
         m_ov  = 1;
         m_oid = k;
      end else if (bus.out_ready) begin
         m_ov = 0;
      end
      for (int i = 0; i < NREQ; i++)
         if (bus.in_valid[i] && !pre_full[i]) chan_q[i].push_back(bus.in_data[i*DW +: DW]);
      if (n > 1) m_err = 1;
      if (n > 0 && !tk && m_drop < 255) m_drop++;
   endtask

   function automatic logic [NREQ*DW-1:0] put(input logic [NREQ*DW-1:0] d, input int ch,
                                               input logic [DW-1:0] v);
      logic [NREQ*DW-1:0] r;
      r = d;
      r[ch*DW +: DW] = v;
      return r;
   endfunction

   task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d,
                        input logic [NREQ-1:0] g, input logic r);
      @(negedge clk);
      bus.in_valid = v; bus.in_data = d; bus.gnt = g; bus.out_ready = r;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.in_valid = '0; bus.in_data = '0; bus.gnt = '0; bus.out_ready = 1'b0;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = '0; bus.in_data = '0; bus.gnt = '0; bus.out_ready = 1'b0;
      model_reset();
      #2;
      n_cmp++;
      if (bus.in_ready !== 16'hFFFF || bus.req !== 16'h0000) begin
         n_mis++;
         $display("FAIL reset_ready_req: got in_ready=%h req=%h want FFFF 0000", bus.in_ready, bus.req);
      end
      n_cmp++;
      if ({bus.out_valid, bus.out_data, bus.out_id, bus.gnt_err, bus.drop_cnt} !== '0) begin
         n_mis++;
         $display("FAIL reset_outputs: got v=%b d=%h id=%0d err=%b drop=%0d want all zero",
                  bus.out_valid, bus.out_data, bus.out_id, bus.gnt_err, bus.drop_cnt);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      drive(16'h0008, put('0, 3, 8'hA5), 16'h0000, 1'b1);
      tick();
      n_cmp++;
      if (bus.req !== 16'h0008 || bus.in_ready !== 16'hFFF7) begin
         n_mis++;
         $display("FAIL single_req: got req=%h in_ready=%h want 0008 FFF7", bus.req, bus.in_ready);
      end
      drive(16'h0000, '0, 16'h0008, 1'b1);
      n_cmp++;
      if (bus.req !== 16'h0000) begin
         n_mis++;
         $display("FAIL single_req_take: got req=%h want 0000", bus.req);
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.out_id !== 4'd3) begin
         n_mis++;
         $display("FAIL single_out: got v=%b d=%h id=%0d want 1 A5 3", bus.out_valid, bus.out_data, bus.out_id);
      end
   endtask

   task automatic test_back_to_back();
      int            ids [3] = '{0, 5, 15};
      logic [DW-1:0] dat [3] = '{8'h11, 8'h55, 8'hF0};
      logic [NREQ*DW-1:0] d = '0;
      do_reset();
      for (int i = 0; i < 3; i++) d = put(d, ids[i], dat[i]);
      drive(16'h8021, d, 16'h0000, 1'b1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(16'h0000, '0, 16'(1) << ids[i], 1'b1);
         tick();
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.out_id !== 4'(ids[i]) || bus.out_data !== dat[i]) begin
            n_mis++;
            $display("FAIL b2b_out%0d: got v=%b id=%0d d=%h want 1 %0d %h",
                     i, bus.out_valid, bus.out_id, bus.out_data, ids[i], dat[i]);
         end
      end
      drive(16'h0000, '0, 16'h0000, 1'b1);
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 16'hFFFF) begin
         n_mis++;
         $display("FAIL b2b_drain: got v=%b in_ready=%h want 0 FFFF", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_stall();
      do_reset();
      drive(16'h0021, put(put('0, 0, 8'h0A), 5, 8'h5B), 16'h0000, 1'b0);
      tick();
      drive(16'h0000, '0, 16'h0001, 1'b0);
      tick();
      drive(16'h0000, '0, 16'h0020, 1'b0);
      tick();
      n_cmp++;
      if (bus.out_id !== 4'd0 || bus.in_ready[5] !== 1'b0 || bus.req[5] !== 1'b1) begin
         n_mis++;
         $display("FAIL stall_hold: got id=%0d in_ready5=%b req5=%b want 0 0 1", bus.out_id, bus.in_ready[5], bus.req[5]);
      end
      n_cmp++;
      if (bus.drop_cnt !== (STATS ? 8'd1 : 8'd0)) begin
         n_mis++;
         $display("FAIL stall_drop: got %0d want %0d", bus.drop_cnt, STATS ? 1 : 0);
      end
      drive(16'h0000, '0, 16'h0020, 1'b1);
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_id !== 4'd5 || bus.out_data !== 8'h5B) begin
         n_mis++;
         $display("FAIL stall_regrant: got v=%b id=%0d d=%h want 1 5 5B", bus.out_valid, bus.out_id, bus.out_data);
      end
   endtask

   task automatic test_multi_gnt();
      do_reset();
      drive(16'h0011, put(put('0, 0, 8'h01), 4, 8'h04), 16'h0000, 1'b1);
      tick();
      drive(16'h0000, '0, 16'h0011, 1'b1);
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.gnt_err !== 1'b1 || bus.in_ready !== 16'hFFEE) begin
         n_mis++;
         $display("FAIL multi_gnt: got v=%b err=%b in_ready=%h want 0 1 FFEE", bus.out_valid, bus.gnt_err, bus.in_ready);
      end
      drive(16'h0000, '0, 16'h0000, 1'b1);
      repeat (3) tick();
      n_cmp++;
      if (bus.gnt_err !== 1'b1) begin
         n_mis++;
         $display("FAIL multi_sticky: got err=%b want 1", bus.gnt_err);
      end
      do_reset();
      #1;
      n_cmp++;
      if (bus.gnt_err !== 1'b0) begin
         n_mis++;
         $display("FAIL multi_clear: got err=%b want 0", bus.gnt_err);
      end
   endtask

   task automatic test_stale_saturate();
      do_reset();
      drive(16'h0000, '0, 16'h0004, 1'b1);
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.drop_cnt !== exp_drop() || bus.drop_cnt !== (STATS ? 8'd1 : 8'd0)) begin
         n_mis++;
         $display("FAIL stale_one: got v=%b drop=%0d want 0 %0d", bus.out_valid, bus.drop_cnt, exp_drop());
      end
      repeat (299) tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.drop_cnt !== (STATS ? 8'hFF : 8'h00)) begin
         n_mis++;
         $display("FAIL stale_sat: got v=%b drop=%0d want 0 %0d", bus.out_valid, bus.drop_cnt, STATS ? 255 : 0);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(16'h0082 | 16'h0008, put(put(put('0, 1, 8'h11), 7, 8'h77), 3, 8'h3C), 16'h0000, 1'b0);
      tick();
      drive(16'h0000, '0, 16'h0008, 1'b0);
      tick();
      drive(16'h0000, '0, 16'h0003, 1'b0);
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C || bus.in_ready !== 16'hFF7D || bus.gnt_err !== 1'b1) begin
         n_mis++;
         $display("FAIL areset_pre: got v=%b d=%h in_ready=%h err=%b want 1 3C FF7D 1",
                  bus.out_valid, bus.out_data, bus.in_ready, bus.gnt_err);
      end
      @(negedge clk);
      bus.gnt = '0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if (bus.in_ready !== 16'hFFFF || bus.req !== '0 ||
          {bus.out_valid, bus.out_data, bus.out_id, bus.gnt_err, bus.drop_cnt} !== '0) begin
         n_mis++;
         $display("FAIL areset_async: got in_ready=%h req=%h v=%b d=%h id=%0d err=%b drop=%0d want FFFF 0 all-zero",
                  bus.in_ready, bus.req, bus.out_valid, bus.out_data, bus.out_id, bus.gnt_err, bus.drop_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(16'h0002, put('0, 1, 8'h99), 16'h0000, 1'b1);
      tick();
      n_cmp++;
      if (bus.in_ready !== 16'hFFFD || bus.req !== 16'h0002) begin
         n_mis++;
         $display("FAIL areset_first_accept: got in_ready=%h req=%h want FFFD 0002", bus.in_ready, bus.req);
      end
   endtask

   task automatic test_random();
      logic [NREQ-1:0]    v, g;
      logic [NREQ*DW-1:0] d;
      int                 sel;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         v = 16'($urandom);
         for (int w = 0; w < NREQ*DW/32; w++) d[w*32 +: 32] = $urandom;
         sel = $urandom_range(0, 19);
         if (sel < 13)      g = 16'(1) << $urandom_range(0, NREQ-1);
         else if (sel < 17) g = '0;
         else               g = 16'($urandom) | 16'h0101;
         if (c > 300 && sel >= 17) g = 16'(1) << $urandom_range(0, NREQ-1);
         drive(v, d, g, 1'($urandom_range(0, 3) != 0));
         n_cmp++;
         if (bus.req !== exp_req() || bus.in_ready !== exp_ready()) begin
            n_mis++;
            $display("FAIL rand_comb[%0d]: got req=%h in_ready=%h want %h %h",
                     c, bus.req, bus.in_ready, exp_req(), exp_ready());
         end
         tick();
         n_cmp++;
         if (bus.out_valid !== m_ov || bus.out_data !== m_od || bus.out_id !== 4'(m_oid) ||
             bus.gnt_err !== m_err || bus.drop_cnt !== exp_drop()) begin
            n_mis++;
            $display("FAIL rand_out[%0d]: got v=%b d=%h id=%0d err=%b drop=%0d want %b %h %0d %b %0d",
                     c, bus.out_valid, bus.out_data, bus.out_id, bus.gnt_err, bus.drop_cnt,
                     m_ov, m_od, m_oid, m_err, exp_drop());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_multi_gnt();
      test_stale_saturate();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/arb_req_stage.md
ARB_REQ_STAGE -- requirements
Module: arb_req_stage

Interface
REQ-001 Parameter DW, default 8: payload width per requester.
REQ-002 Parameter NREQ, fixed 16: requester count, matches the 16-bit round-robin arbiter.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; one clock, asynchronous assert, active-low.
REQ-005 in_valid  input  16  per-requester payload valid.
REQ-006 in_data  input  16*DW  payloads; channel i at bits [i*DW +: DW].
REQ-007 in_ready  output  16  per-requester accept.
REQ-008 req  output  16  request vector to arbiter.
REQ-009 gnt  input  16  registered one-hot grant from arbiter.
REQ-010 out_valid  output  1  granted payload valid.
REQ-011 out_data  output  DW  granted payload.
REQ-012 out_id  output  4  index of granted channel.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 gnt_err  output  1  sticky: non-one-hot grant seen.
REQ-015 drop_cnt  output  8  grants not consumed (see Configuration).

Function
REQ-016 Each channel SHALL own a 1-entry holding register (hold_v[i], hold_d[i]).
REQ-017 in_ready[i] SHALL equal ~hold_v[i]; capture on in_valid[i] & in_ready[i].
REQ-018 Output stage empty-or-draining: can_load = ~out_valid | out_ready.
REQ-019 Grant accepted (take) when gnt one-hot, hold_v[k]=1 for set bit k, and can_load=1.
REQ-020 On take: out_data<=hold_d[k], out_id<=k, out_valid<=1, hold_v[k]<=0, next cycle; latency gnt->out_valid one cycle.
REQ-021 req[i] SHALL be hold_v[i] & ~(take & gnt[i]), combinational, so a consumed channel never re-requests in its pop cycle.
REQ-022 out_valid SHALL clear on out_valid & out_ready with no take same cycle; take+drain same cycle SHALL replace contents, no bubble.
REQ-023 Grant with hold_v[k]=0 (stale) or can_load=0 (stall) SHALL be dropped; hold_v unchanged, req stays high for later re-grant.
REQ-024 gnt with >1 bit set SHALL be dropped and set gnt_err until reset; gnt=0 is idle, not error.
REQ-025 Same-cycle pop and refill of a channel is not permitted: in_ready[i] reflects pre-pop state.
REQ-026 Payload order per channel SHALL be preserved; no payload lost or duplicated.

Reset
REQ-027 rst_n low SHALL immediately clear hold_v, out_valid, gnt_err, drop_cnt; in_ready=16'hFFFF, req=0, out_data=0, out_id=0.
REQ-028 Reset mid-transfer SHALL discard all held payloads; first accept allowed first rising edge after release.

Configuration
REQ-029 Macro ARB_REQ_STAGE_STATS_EN defined: drop_cnt counts every dropped grant (REQ-023/024), saturating at 8'hFF.
REQ-030 Macro undefined: counter logic absent, drop_cnt tied 8'h00; all other behaviour identical.

Structure
REQ-031 Package arb_pkg SHALL hold NREQ=16, IDW=4, and the one-hot-to-index function shared with the arbiter.
REQ-032 One sub-module arb_onehot_enc: 16-bit one-hot -> 4-bit index plus onehot_ok flag.

Verification
REQ-033 Reset, in_valid[3]=1 data 8'hA5, gnt=16'h0008 next cycle, out_ready=1 -> req[3] high, then out_valid=1, out_data=A5, out_id=3; req[3] low during take.
REQ-034 Channels 0,5,15 loaded; gnt 0x0001,0x0020,0x8000 consecutive, out_ready=1 -> three back-to-back outputs ids 0,5,15, no bubble.
REQ-035 out_valid=1, out_ready=0, gnt=0x0020 -> dropped, hold_v[5] stays 1, drop_cnt=1 with STATS_EN (0 without); later re-grant delivers.
REQ-036 gnt=0x0011 -> nothing popped, gnt_err=1 until rst_n low.
REQ-037 Stale gnt=0x0004 with hold_v[2]=0 -> no output, drop_cnt increments; 300 stale grants -> drop_cnt saturates 8'hFF.
REQ-038 rst_n low while channels 1,7 held and out_valid=1 -> all outputs to reset values asynchronously, in_ready=16'hFFFF.
